pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised successor to the IF-stage PC register; generates the instruction fetch address and fetch enable.
- Supports NUM_REDIR prioritised redirect channels (e.g. exception, branch), configurable reset vector and step, and stall-safe buffering of redirects.
- Outputs a one-cycle redirect pulse and alignment flag to IF/ID.
- Sits at the head of IF and drives the instruction memory address/enable.

Parameters:
ADDR_W, 32, width of PC and redirect addresses
RESET_VEC, 32'h8000_0000, first fetch address after reset
STEP, 4, sequential PC increment
NUM_REDIR, 2, number of redirect channels; index 0 is highest priority
ALIGN_BITS, 2, low address bits that must be zero; 0 disables the check

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stops_stop  input  1  pipeline stall; hold pc and ce
redir_valid_i  input  NUM_REDIR  per-channel redirect request
redir_addr_i  input  NUM_REDIR*ADDR_W  packed targets; channel k at bits [k*ADDR_W +: ADDR_W]
pc  output  ADDR_W  fetch address
ce  output  1  fetch enable (read)
redir_taken_o  output  1  pulse: pc this cycle was loaded from a redirect
redir_src_o  output  IDXW  channel that produced current pc; IDXW = max(1, clog2(NUM_REDIR))
misalign_o  output  1  current pc has nonzero low ALIGN_BITS bits

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_VEC, ce=0, redir_taken_o=0, redir_src_o=0, misalign_o=0.
  - Pending buffer is cleared and started=0.
  - Reset overrides stall and redirects, including mid-stall with a pending redirect.
- Internal state:
  - started flag.
  - Pending buffer: pend_v, pend_idx, pend_addr.
- Live winner: lowest index k with redir_valid_i[k]=1.
- Stall cycle (stops_stop=1):
  - pc, ce, redir_src_o and misalign_o hold; redir_taken_o=0.
  - If a live winner exists and (!pend_v or winner idx <= pend_idx), load the pending buffer with the winner. A tie replaces the buffered entry.
- Unstalled cycle, evaluated in this order:
  1. Pending and/or live redirect:
     - Select the pending entry if pend_v and (no live winner or pend_idx < live idx); otherwise the live winner.
     - pc=target, ce=1, redir_taken_o=1, redir_src_o=idx, pend_v cleared, started=1.
  2. No redirect and started=0: ce=1, pc stays RESET_VEC, started=1. RESET_VEC is fetched exactly once.
  3. Otherwise: pc=pc+STEP modulo 2^ADDR_W (wraps from all-ones region to low addresses, no flag), ce=1, redir_taken_o=0.
- Latency: redirect sampled at edge N appears on pc after edge N, i.e. one cycle. Sequential next address is computed from the current pc; no separate next_pc register.
- misalign_o: registered with pc. Equals |pc_new[ALIGN_BITS-1:0] when ALIGN_BITS>0, else 0. pc is never forced aligned.
- redir_taken_o: high for exactly one cycle per applied redirect. Redirects on back-to-back unstalled cycles give consecutive pulses.
- Stall asserted in the same cycle as redirect: the redirect is buffered, not lost. It applies on the first unstalled edge.
- NUM_REDIR=1: pend_idx comparisons degenerate; the newest redirect wins.

Test Plan:
- Reset release, no stall, no redirect, RESET_VEC=0x8000_0000, STEP=4 -> first ce=1 cycle pc=0x8000_0000, then 0x8000_0004, 0x8000_0008; redir_taken_o=0.
- Unstalled, pc=0x8000_0010, redir_valid_i=2'b11, ch0=0x8000_0180, ch1=0x8000_0400 -> next pc=0x8000_0180, redir_src_o=0, redir_taken_o=1 for one cycle, then 0x8000_0184.
- Stall 3 cycles: ch1=0x8000_0200 in stall cycle 1, ch0=0x8000_0300 in stall cycle 2, release with no live redirect -> pc held during stall, then pc=0x8000_0300, src=0.
- Stall with pending ch0=0x100, release cycle has live ch1=0x200 -> pc=0x100 (pending strictly higher priority); repeat with live ch0=0x200 -> pc=0x200.
- Redirect to 0x8000_0102 with ALIGN_BITS=2 -> misalign_o=1 with that pc; next pc 0x8000_0106 keeps misalign_o=1; redirect to 0x8000_0200 clears it.
- ADDR_W=32, pc=0xFFFF_FFFC, unstalled -> pc=0x0000_0000. Then rst=1 during stall with pend_v=1 -> pc=RESET_VEC, ce=0, pending discarded after release.

Source files
------------

// File: rtl/pc_gen.sv
// Instruction fetch address generator: sequential PC stepping, prioritised redirects,
// and a stall-safe pending buffer so a redirect seen during a stall is never lost.
module pc_gen #(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h8000_0000,
    parameter int              STEP       = 4,
    parameter int              NUM_REDIR  = 2,
    parameter int              ALIGN_BITS = 2,
    localparam int             IDXW       = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stops_stop,
    input  logic [NUM_REDIR-1:0]          redir_valid_i,
    input  logic [NUM_REDIR*ADDR_W-1:0]   redir_addr_i,
    output logic [ADDR_W-1:0]             pc,
    output logic                          ce,
    output logic                          redir_taken_o,
    output logic [IDXW-1:0]               redir_src_o,
    output logic                          misalign_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

    logic              started;
    logic              pend_v;
    logic [IDXW-1:0]   pend_idx;
    logic [ADDR_W-1:0] pend_addr;

    logic              live_v;
    logic [IDXW-1:0]   live_idx;
    logic [ADDR_W-1:0] live_addr;
    logic              use_pend;
    logic              sel_v;
    logic [IDXW-1:0]   sel_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] pc_d;

    // Scan from the highest index down so the lowest valid channel is the last write.
    always_comb begin
        live_v    = 1'b0;
        live_idx  = '0;
        live_addr = '0;
        for (int k = NUM_REDIR - 1; k >= 0; k--) begin
            if (redir_valid_i[k]) begin
                live_v    = 1'b1;
                live_idx  = IDXW'(k);
                live_addr = redir_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // A buffered redirect only beats a live one when strictly higher priority.
    always_comb begin
        use_pend = pend_v && (!live_v || (pend_idx < live_idx));
        sel_v    = use_pend || live_v;
        sel_idx  = use_pend ? pend_idx  : live_idx;
        sel_addr = use_pend ? pend_addr : live_addr;
        if (sel_v)
            pc_d = sel_addr;
        else if (!started)
            pc_d = pc;
        else
            pc_d = pc + ADDR_W'(STEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_VEC;
            ce            <= 1'b0;
            redir_taken_o <= 1'b0;
            redir_src_o   <= '0;
            misalign_o    <= 1'b0;
            started       <= 1'b0;
            pend_v        <= 1'b0;
            pend_idx      <= '0;
            pend_addr     <= '0;
        end else if (stops_stop) begin
            redir_taken_o <= 1'b0;
            if (live_v && (!pend_v || (live_idx <= pend_idx))) begin
                pend_v    <= 1'b1;
                pend_idx  <= live_idx;
                pend_addr <= live_addr;
            end
        end else begin
            pc            <= pc_d;
            ce            <= 1'b1;
            started       <= 1'b1;
            redir_taken_o <= sel_v;
            misalign_o    <= |(pc_d & ALIGN_MASK);
            if (sel_v) begin
                redir_src_o <= sel_idx;
                pend_v      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed vector table for the documented scenarios,
// then randomized traffic compared against a behavioural model.
module tb_pc_gen;

    localparam int ADDR_W = 32;
    localparam int NUM_REDIR = 2;
    localparam logic [31:0] RESET_VEC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stops_stop;
    logic [1:0]  redir_valid_i;
    logic [63:0] redir_addr_i;
    logic [31:0] pc;
    logic        ce;
    logic        redir_taken_o;
    logic [0:0]  redir_src_o;
    logic        misalign_o;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural reference state
    logic [31:0] m_pc;
    logic        m_ce, m_taken, m_mis, m_started, m_pend_v;
    int          m_src, m_pend_idx;
    logic [31:0] m_pend_addr;

    typedef struct {
        logic        rst;
        logic        stall;
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] pc;
        logic        ce;
        logic        taken;
        logic        src;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    pc_gen #(
        .ADDR_W(ADDR_W), .RESET_VEC(RESET_VEC), .STEP(4), .NUM_REDIR(NUM_REDIR), .ALIGN_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .stops_stop(stops_stop),
        .redir_valid_i(redir_valid_i), .redir_addr_i(redir_addr_i),
        .pc(pc), .ce(ce), .redir_taken_o(redir_taken_o),
        .redir_src_o(redir_src_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] v,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] epc, input logic ece, input logic etk,
                                input logic esrc, input logic emis);
        vec_t t;
        t.rst = r; t.stall = s; t.valid = v; t.a0 = a0; t.a1 = a1;
        t.pc = epc; t.ce = ece; t.taken = etk; t.src = esrc; t.mis = emis;
        return t;
    endfunction

    // Model: one clock edge of the specified behaviour.
    task automatic modelStep(input logic r, input logic s, input logic [1:0] v,
                             input logic [31:0] a0, input logic [31:0] a1);
        int w;
        logic [31:0] waddr;
        w = -1;
        waddr = 0;
        if (v[1]) begin w = 1; waddr = a1; end
        if (v[0]) begin w = 0; waddr = a0; end
        if (r) begin
            m_pc = RESET_VEC; m_ce = 0; m_taken = 0; m_src = 0; m_mis = 0;
            m_pend_v = 0; m_started = 0;
        end else if (s) begin
            m_taken = 0;
            if (w >= 0 && (!m_pend_v || w <= m_pend_idx)) begin
                m_pend_v = 1; m_pend_idx = w; m_pend_addr = waddr;
            end
        end else begin
            m_ce = 1;
            if (m_pend_v && (w < 0 || m_pend_idx < w)) begin
                m_pc = m_pend_addr; m_src = m_pend_idx; m_taken = 1;
            end else if (w >= 0) begin
                m_pc = waddr; m_src = w; m_taken = 1;
            end else if (!m_started) begin
                m_taken = 0;
            end else begin
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
                m_taken = 0;
            end
            m_pend_v = m_pend_v && 1'b0;
            m_started = 1;
            m_mis = (m_pc % 4) != 0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] v,
                                 input logic [31:0] a0, input logic [31:0] a1);
        rst = r; stops_stop = s; redir_valid_i = v; redir_addr_i = {a1, a0};
        modelStep(r, s, v, a0, a1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] epc, input logic ece,
                               input logic etk, input logic esrc, input logic emis);
        vectors++;
        if (pc !== epc) begin
            miscompares++;
            $display("[TB] FAIL %s pc: got %h expected %h", tag, pc, epc);
        end
        if (ce !== ece) begin
            miscompares++;
            $display("[TB] FAIL %s ce: got %b expected %b", tag, ce, ece);
        end
        if (redir_taken_o !== etk) begin
            miscompares++;
            $display("[TB] FAIL %s taken: got %b expected %b", tag, redir_taken_o, etk);
        end
        if (redir_src_o !== esrc) begin
            miscompares++;
            $display("[TB] FAIL %s src: got %b expected %b", tag, redir_src_o, esrc);
        end
        if (misalign_o !== emis) begin
            miscompares++;
            $display("[TB] FAIL %s misalign: got %b expected %b", tag, misalign_o, emis);
        end
    endtask

    initial begin
        logic [1:0] rv;
        logic [31:0] ra0, ra1;
        rst = 1; stops_stop = 0; redir_valid_i = 0; redir_addr_i = 0;
        m_pc = 0; m_ce = 0; m_taken = 0; m_mis = 0; m_started = 0;
        m_pend_v = 0; m_src = 0; m_pend_idx = 0; m_pend_addr = 0;

        //           rst stall valid a0             a1             pc             ce tk src mis
        vecs.push_back(mk(1, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0004, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0008, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_000C, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0010, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b11, 32'h8000_0180, 32'h8000_0400, 32'h8000_0180, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0184, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 32'h0,          32'h8000_0200, 32'h8000_0184, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 32'h8000_0300, 32'h0,          32'h8000_0184, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b00, 32'h0,          32'h0,          32'h8000_0184, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0300, 1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 32'h100,        32'h0,          32'h8000_0300, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b10, 32'h0,          32'h200,        32'h100,        1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'b01, 32'h100,        32'h0,          32'h100,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b01, 32'h200,        32'h0,          32'h200,        1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b10, 32'h0,          32'h8000_0102, 32'h8000_0102, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0106, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 2'b01, 32'h8000_0200, 32'h0,          32'h8000_0200, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b01, 32'hFFFF_FFFC, 32'h0,          32'hFFFF_FFFC, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h0000_0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'b10, 32'h0,          32'h1234_0000, 32'h0000_0000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2'b00, 32'h0,          32'h0,          32'h8000_0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'b00, 32'h0,          32'h0,          32'h8000_0004, 1, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].valid, vecs[i].a0, vecs[i].a1);
            checkOutput($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ce,
                        vecs[i].taken, vecs[i].src, vecs[i].mis);
        end

        // Randomized traffic against the model; occasional unaligned targets and resets.
        for (int i = 0; i < 600; i++) begin
            rv  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            ra0 = $urandom;
            ra1 = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                ra0[1:0] = 2'b00;
                ra1[1:0] = 2'b00;
            end
            applyStimulus(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) == 0), rv, ra0, ra1);
            checkOutput($sformatf("rnd%0d", i), m_pc, m_ce, m_taken, 1'(m_src), m_mis);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
